// File: rtl/hamming_class_search.sv
// rtl/hamming_class_search.sv - buffers a query hypervector and finds the nearest class by Hamming distance
module hamming_class_search #(
  parameter int FRAME_WIDTH = 64,
  parameter int NUM_FRAMES  = 3,
  parameter int NUM_CLASSES = 8,
  parameter int CLASS_W     = 3,
  parameter int FIDX_W      = 2,
  parameter int DIST_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [FRAME_WIDTH-1:0] q_frame,
  output logic [CLASS_W-1:0]     frame_id,
  output logic [FIDX_W-1:0]      frame_index,
  input  logic [FRAME_WIDTH-1:0] class_vec_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CLASS_W-1:0]     res_class,
  output logic [DIST_W-1:0]      res_dist,
  output logic                   busy
);

  localparam int PC_W = $clog2(FRAME_WIDTH + 1);
  localparam logic [FIDX_W-1:0]  LAST_FRM = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

  state_t                 state_q;
  logic [FRAME_WIDTH-1:0] qbuf_q [NUM_FRAMES];
  logic [FIDX_W-1:0]      load_cnt_q;
  logic [CLASS_W-1:0]     cls_q;
  logic [FIDX_W-1:0]      frm_q;
  logic [DIST_W-1:0]      acc_q;
  logic [DIST_W-1:0]      best_dist_q;
  logic [CLASS_W-1:0]     best_cls_q;
  logic [CLASS_W-1:0]     res_class_q;
  logic [DIST_W-1:0]      res_dist_q;
  logic                   res_valid_q;

  logic [PC_W-1:0]        part;
  logic [DIST_W-1:0]      total;
  logic                   take_new;
  logic [DIST_W-1:0]      best_dist_d;
  logic [CLASS_W-1:0]     best_cls_d;

  function automatic logic [PC_W-1:0] popcount(input logic [FRAME_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < FRAME_WIDTH; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Distance of the current frame and the running class total; class 0 always seeds the best,
  // later classes replace it only when strictly closer so ties keep the lower id.
  always_comb begin
    part        = popcount(qbuf_q[frm_q] ^ class_vec_in);
    total       = acc_q + DIST_W'(part);
    take_new    = (cls_q == '0) || (total < best_dist_q);
    best_dist_d = take_new ? total : best_dist_q;
    best_cls_d  = take_new ? cls_q : best_cls_q;
  end

  assign q_ready     = (state_q == LOAD);
  assign busy        = (state_q == SEARCH);
  assign frame_id    = cls_q;
  assign frame_index = frm_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign res_dist    = res_dist_q;

  // Load / search / done sequencing; cls and frm return to zero outside SEARCH so the
  // generator select reads (0,0) in LOAD and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      for (int i = 0; i < NUM_FRAMES; i++) qbuf_q[i] <= '0;
      load_cnt_q  <= '0;
      cls_q       <= '0;
      frm_q       <= '0;
      acc_q       <= '0;
      best_dist_q <= '0;
      best_cls_q  <= '0;
      res_class_q <= '0;
      res_dist_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (q_valid) begin
            qbuf_q[load_cnt_q] <= q_frame;
            if (load_cnt_q == LAST_FRM) begin
              state_q    <= SEARCH;
              load_cnt_q <= '0;
              cls_q      <= '0;
              frm_q      <= '0;
              acc_q      <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (frm_q != LAST_FRM) begin
            acc_q <= total;
            frm_q <= frm_q + 1'b1;
          end else begin
            best_dist_q <= best_dist_d;
            best_cls_q  <= best_cls_d;
            acc_q       <= '0;
            frm_q       <= '0;
            if (cls_q == LAST_CLS) begin
              cls_q       <= '0;
              res_class_q <= best_cls_d;
              res_dist_q  <= best_dist_d;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cls_q <= cls_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_class_search.sv
// tb/tb_hamming_class_search.sv - directed vector bench for hamming_class_search
module tb_hamming_class_search;

  logic        clk;
  logic        rst_n;
  logic        q_valid;
  logic        q_ready;
  logic [63:0] q_frame;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_class;
  logic [7:0]  res_dist;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int class_mode;

  hamming_class_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .q_frame      (q_frame),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_class    (res_class),
    .res_dist     (res_dist),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Class generator model: 0 all zero, 1 class 5 all ones, 2 class c has c+1 LSB ones
  always_comb begin
    int ones;
    class_vec_in = '0;
    ones = int'(frame_id) + 1;
    case (class_mode)
      1: class_vec_in = (frame_id == 3'd5) ? {64{1'b1}} : 64'd0;
      2: class_vec_in = (64'd1 << ones) - 64'd1;
      default: class_vec_in = '0;
    endcase
  end

  typedef struct {
    int          mode;
    logic [63:0] query;
    int          exp_cls;
    int          exp_dist;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q_ready"},     32'(q_ready),     32'd1);
    check({tag, "_res_valid"},   32'(res_valid),   32'd0);
    check({tag, "_res_class"},   32'(res_class),   32'd0);
    check({tag, "_res_dist"},    32'(res_dist),    32'd0);
    check({tag, "_frame_id"},    32'(frame_id),    32'd0);
    check({tag, "_frame_index"}, 32'(frame_index), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  // Ends on the negedge after the edge that accepted the last beat
  task automatic send_query(input logic [63:0] f);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("q_ready_load", 32'(q_ready), 32'd1);
      q_valid = 1'b1;
      q_frame = f;
      @(posedge clk);
    end
    @(negedge clk);
    q_valid = 1'b0;
    q_frame = '0;
  endtask

  // Walks the 24 search cycles then checks the DONE outputs
  task automatic run_search(input int exp_cls, input int exp_dist);
    for (int k = 0; k < 24; k++) begin
      check("scan_frame_id",    32'(frame_id),    32'(k / 3));
      check("scan_frame_index", 32'(frame_index), 32'(k % 3));
      check("scan_busy",        32'(busy),        32'd1);
      check("scan_res_valid",   32'(res_valid),   32'd0);
      check("scan_q_ready",     32'(q_ready),     32'd0);
      @(negedge clk);
    end
    check("done_res_valid",   32'(res_valid),   32'd1);
    check("done_busy",        32'(busy),        32'd0);
    check("done_frame_id",    32'(frame_id),    32'd0);
    check("done_frame_index", 32'(frame_index), 32'd0);
    check("done_res_class",   32'(res_class),   32'(exp_cls));
    check("done_res_dist",    32'(res_dist),    32'(exp_dist));
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_hs_q_ready",   32'(q_ready),   32'd1);
    check("post_hs_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 1, query: {64{1'b1}}, exp_cls: 5, exp_dist: 0};
    vecs[1] = '{mode: 0, query: 64'd0,      exp_cls: 0, exp_dist: 0};
    vecs[2] = '{mode: 0, query: {64{1'b1}}, exp_cls: 0, exp_dist: 192};
    vecs[3] = '{mode: 2, query: 64'd0,      exp_cls: 0, exp_dist: 3};
    vecs[4] = '{mode: 1, query: 64'd0,      exp_cls: 0, exp_dist: 0};
    vecs[5] = '{mode: 2, query: {64{1'b1}}, exp_cls: 7, exp_dist: 168};

    class_mode = 0;
    rst_n      = 1'b0;
    q_valid    = 1'b0;
    q_frame    = '0;
    res_ready  = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      class_mode = vecs[v].mode;
      send_query(vecs[v].query);
      run_search(vecs[v].exp_cls, vecs[v].exp_dist);
      take_result();
    end

    // Backpressure: result held, q_valid ignored while DONE
    class_mode = 1;
    send_query({64{1'b1}});
    run_search(5, 0);
    q_valid = 1'b1;
    q_frame = 64'hDEAD_BEEF_0123_4567;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_q_ready",   32'(q_ready),   32'd0);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_class", 32'(res_class), 32'd5);
      check("bp_res_dist",  32'(res_dist),  32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    q_valid   = 1'b0;
    q_frame   = '0;
    check("bp_release_q_ready", 32'(q_ready), 32'd1);
    // A consumed stray beat would shift the next query's framing
    class_mode = 1;
    send_query(64'd0);
    run_search(0, 0);
    take_result();

    // Reset mid-search, then a fresh class-5 query
    class_mode = 1;
    send_query({64{1'b1}});
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send_query({64{1'b1}});
    run_search(5, 0);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_class_search.md
# hamming_class_search

Associative-search stage that sits directly downstream of the class hypervector generator. It buffers one encoded query hypervector, delivered as NUM_FRAMES frames of FRAME_WIDTH bits. It then drives frame_id/frame_index to the combinational class generator, and accumulates the Hamming distance between each class vector and the query, one frame per cycle. It returns the class with minimum distance over a valid/ready handshake.

## Interface
- FRAME_WIDTH, 64, bits per frame
- NUM_FRAMES, 3, frames per hypervector (192-bit vector)
- NUM_CLASSES, 8, classes searched
- CLASS_W, 3, width of frame_id / res_class
- FIDX_W, 2, width of frame_index
- DIST_W, 8, distance width; must hold FRAME_WIDTH*NUM_FRAMES

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- q_valid  in  1  query frame valid
- q_ready  out  1  block accepts a query frame
- q_frame  in  FRAME_WIDTH  query frame; frames arrive in index order 0..NUM_FRAMES-1
- frame_id  out  CLASS_W  class select to the generator
- frame_index  out  FIDX_W  frame select to the generator
- class_vec_in  in  FRAME_WIDTH  generator output for (frame_id, frame_index), same cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_class  out  CLASS_W  winning class
- res_dist  out  DIST_W  winning Hamming distance
- busy  out  1  high in SEARCH

## Operation
- FSM states: LOAD, SEARCH, DONE. Reset state: LOAD.
- LOAD:
  - q_ready=1.
  - Each q_valid&q_ready beat writes qbuf[load_cnt] and increments load_cnt.
  - The beat with load_cnt==NUM_FRAMES-1 moves the FSM to SEARCH and clears cls, frm, acc and load_cnt.
- SEARCH:
  - frame_id=cls and frame_index=frm are registered outputs.
  - Each cycle: part = popcount(qbuf[frm] ^ class_vec_in), 0..FRAME_WIDTH.
  - If frm<NUM_FRAMES-1: acc += part, frm++.
  - If frm==NUM_FRAMES-1: total = acc+part.
    - If cls==0 or total < best_dist, then best_dist=total and best_cls=cls.
    - acc=0, frm=0, cls++.
  - If additionally cls==NUM_CLASSES-1: transfer best into res_class/res_dist, set res_valid, go to DONE.
- Ties use strict less-than, so the lowest class id wins.
- DONE:
  - res_valid=1; res_class and res_dist are held stable.
  - frame_id and frame_index are 0.
  - On res_valid&res_ready: clear res_valid and go to LOAD.
- Signals by state:
  - q_ready is high only in LOAD.
  - q_valid in SEARCH or DONE is ignored; no beat is consumed.
  - busy is high only in SEARCH.
- Arithmetic: popcount is $clog2(FRAME_WIDTH+1) bits. acc, best_dist and res_dist are DIST_W bits. No overflow is possible, since the maximum is 192.
- Reset values: q_ready=1, res_valid=0, res_class=0, res_dist=0, frame_id=0, frame_index=0, busy=0. Internal counters, acc and best are 0.
- Asserting rst_n low at any point, including mid-SEARCH or in DONE, immediately returns all outputs to reset values. The partial query and the pending result are discarded.

## Timing
- class_vec_in must settle combinationally within the cycle frame_id/frame_index are presented. The generator has no pipeline register.
- Search length is exactly NUM_CLASSES*NUM_FRAMES cycles (24 at defaults).
- Let edge E0 be the one that accepts the last query beat.
  - frame_id/frame_index = (0,0) are visible after E0.
  - res_valid is high after edge E0+24.
- Back-to-back operation: q_ready is high the cycle after the result handshake edge.
- res_class and res_dist change only on the SEARCH→DONE edge.
- A new query can be accepted at most every NUM_FRAMES + 24 + 1 cycles when res_ready is held high.

## Test plan
- Class-match: bench class model is all-zero except class 5, which is all-ones in every frame. Query all-ones → res_class=5, res_dist=0, res_valid 24 cycles after the last q beat.
- Tie / all-equal: all classes zero, query zero → res_class=0, res_dist=0. Query all-ones → res_class=0, res_dist=192 (full-width check).
- Scan order: monitor (frame_id, frame_index) during SEARCH → exact sequence (0,0),(0,1),(0,2),(1,0)…(7,2), one pair per cycle, 24 total, with busy high throughout.
- Backpressure: hold res_ready low 10 cycles in DONE, and drive q_valid high → q_ready=0, no beat consumed, result stable. Raise res_ready → q_ready=1 on the next cycle.
- Mixed distances: class c frame f = (c+1) ones in the LSBs, query zero → res_class=0, res_dist=3.
- Reset mid-search: pull rst_n low at search cycle 10 → all outputs at reset values immediately. A fresh class-5 query then completes correctly with res_dist=0.
